// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: shares the single rob result-write port among NREQ execution
// units. Each unit owns a one-entry holding buffer (valid/ready handshake); a
// round-robin arbiter forwards one full buffer per cycle into a registered
// rob_* bundle.
// Optional feature macro: WB_ARB_BRANCH_PRIO_EN -- when defined, full buffers
// holding a branch (flags[0]=1) win over non-branch buffers; round-robin order
// still applies within each class.
module rob_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int IDW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*IDW-1:0] req_robid,
    input  logic [NREQ*8-1:0] req_flags,
    input  logic [NREQ*8-1:0] req_wbs,
    input  logic [NREQ*8-1:0] req_value,
    output logic              rob_transmit,
    output logic [IDW-1:0]    rob_robid,
    output logic [7:0]        rob_flags,
    output logic [7:0]        rob_wbs,
    output logic [7:0]        rob_value,
    output logic [2:0]        grant_id
);

    logic [NREQ-1:0] full;
    logic [NREQ-1:0] grant;
    logic [2:0]      last;
    logic            found;

    logic [IDW-1:0]  buf_robid [NREQ];
    logic [7:0]      buf_flags [NREQ];
    logic [7:0]      buf_wbs   [NREQ];
    logic [7:0]      buf_value [NREQ];

    // Round-robin search starting at last+1; pick at most one full buffer, none during flush.
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        req_ready = '0;
`ifdef WB_ARB_BRANCH_PRIO_EN
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!flush && !found && full[j] && buf_flags[j][0] &&
                    (j == (32'(last) + k) % NREQ)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
`endif
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!flush && !found && full[j] &&
                    (j == (32'(last) + k) % NREQ)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            req_ready[j] = !flush && (!full[j] || grant[j]);
        end
    end

    // Holding buffers, rob output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            full         <= '0;
            last         <= 3'(NREQ - 1);
            rob_transmit <= 1'b0;
            rob_robid    <= '0;
            rob_flags    <= '0;
            rob_wbs      <= '0;
            rob_value    <= '0;
            grant_id     <= '0;
        end else if (flush) begin
            full         <= '0;
            rob_transmit <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                // A granted buffer empties this edge, but a new capture refills it.
                if (req_valid[j] && req_ready[j]) begin
                    full[j]      <= 1'b1;
                    buf_robid[j] <= req_robid[j*IDW +: IDW];
                    buf_flags[j] <= req_flags[j*8 +: 8];
                    buf_wbs[j]   <= req_wbs[j*8 +: 8];
                    buf_value[j] <= req_value[j*8 +: 8];
                end else if (grant[j]) begin
                    full[j] <= 1'b0;
                end
                if (grant[j]) begin
                    rob_robid <= buf_robid[j];
                    rob_flags <= buf_flags[j];
                    rob_wbs   <= buf_wbs[j];
                    rob_value <= buf_value[j];
                    grant_id  <= 3'(j);
                    last      <= 3'(j);
                end
            end
            rob_transmit <= found;
        end
    end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// tb_rob_wb_arbiter: directed-vector self-checking bench for rob_wb_arbiter
// (NREQ=3, IDW=4). Inputs change 1 ns after the rising edge; outputs are
// sampled there too, well away from the next active edge.
module tb_rob_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [11:0] req_robid = '0;
    logic [23:0] req_flags = '0;
    logic [23:0] req_wbs = '0;
    logic [23:0] req_value = '0;
    logic        rob_transmit;
    logic [3:0]  rob_robid;
    logic [7:0]  rob_flags;
    logic [7:0]  rob_wbs;
    logic [7:0]  rob_value;
    logic [2:0]  grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    rob_wb_arbiter #(.NREQ(3), .IDW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_robid(req_robid), .req_flags(req_flags),
        .req_wbs(req_wbs), .req_value(req_value),
        .rob_transmit(rob_transmit), .rob_robid(rob_robid),
        .rob_flags(rob_flags), .rob_wbs(rob_wbs), .rob_value(rob_value),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] robid, input logic [7:0] flags,
                           input logic [7:0] wbs, input logic [7:0] value);
        req_robid[i*4 +: 4] = robid;
        req_flags[i*8 +: 8] = flags;
        req_wbs[i*8 +: 8]   = wbs;
        req_value[i*8 +: 8] = value;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int cnt [3];
    int gc  [3];
    logic [2:0] rdy;
    int w;

    initial begin
        // 1: reset values and single-result latency
        #1;
        do_reset();
        check("rst_transmit", 32'(rob_transmit), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_robid", 32'(rob_robid), 0);
        check("rst_ready", 32'(req_ready), 32'h7);
        set_req(0, 4'd3, 8'h00, 8'h21, 8'h5A);
        req_valid = 3'b001;
        #1;
        check("t1_ready0", 32'(req_ready[0]), 1);
        tick();
        req_valid = '0;
        check("t1_not_yet", 32'(rob_transmit), 0);
        tick();
        check("t1_transmit", 32'(rob_transmit), 1);
        check("t1_robid", 32'(rob_robid), 3);
        check("t1_value", 32'(rob_value), 32'h5A);
        check("t1_wbs", 32'(rob_wbs), 32'h21);
        check("t1_grant_id", 32'(grant_id), 0);
        tick();
        check("t1_one_pulse", 32'(rob_transmit), 0);

        // 2: all units streaming, sustained round robin with per-unit ordering
        do_reset();
        for (int i = 0; i < 3; i++) begin cnt[i] = 0; gc[i] = 0; end
        for (int step = 0; step <= 6; step++) begin
            for (int i = 0; i < 3; i++)
                set_req(i, 4'(i), 8'h00, 8'h00, {4'(i), 4'(cnt[i])});
            req_valid = 3'b111;
            #1;
            rdy = req_ready;
            tick();
            for (int i = 0; i < 3; i++) if (rdy[i]) cnt[i]++;
            if (step >= 1) begin
                w = (step - 1) % 3;
                check("t2_grant_id", 32'(grant_id), 32'(w));
                check("t2_transmit", 32'(rob_transmit), 1);
                check("t2_robid", 32'(rob_robid), 32'(w));
                check("t2_value", 32'(rob_value), 32'({4'(w), 4'(gc[w])}));
                gc[w]++;
            end
        end
        req_valid = '0;

        // 3: units 1 and 2 full with last=1; unit 0 idle stays ready
        do_reset();
        set_req(1, 4'd5, 8'h00, 8'h00, 8'h15);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        tick();
        check("t3_setup_gid", 32'(grant_id), 1);
        set_req(1, 4'd6, 8'h00, 8'h00, 8'h16);
        set_req(2, 4'd7, 8'h00, 8'h00, 8'h27);
        req_valid = 3'b110;
        #1;
        check("t3_ready0_a", 32'(req_ready[0]), 1);
        tick();
        req_valid = '0;
        check("t3_ready0_b", 32'(req_ready[0]), 1);
        tick();
        check("t3_first_gid", 32'(grant_id), 2);
        check("t3_first_robid", 32'(rob_robid), 7);
        check("t3_ready0_c", 32'(req_ready[0]), 1);
        tick();
        check("t3_second_gid", 32'(grant_id), 1);
        check("t3_second_robid", 32'(rob_robid), 6);
        tick();
        check("t3_idle", 32'(rob_transmit), 0);

        // 4: flush with all buffers full; nothing stale afterwards
        set_req(0, 4'd8, 8'h00, 8'h00, 8'h80);
        set_req(1, 4'd9, 8'h00, 8'h00, 8'h90);
        set_req(2, 4'd10, 8'h00, 8'h00, 8'hA0);
        req_valid = 3'b111;
        tick();
        set_req(0, 4'd11, 8'h00, 8'h00, 8'hB0);
        set_req(1, 4'd12, 8'h00, 8'h00, 8'hC0);
        set_req(2, 4'd13, 8'h00, 8'h00, 8'hD0);
        flush = 1'b1;
        #1;
        check("t4_ready_flush", 32'(req_ready), 0);
        tick();
        flush = 1'b0;
        req_valid = '0;
        check("t4_transmit_after", 32'(rob_transmit), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_no_stale", 32'(rob_transmit), 0);
        end

        // 5: branch candidate vs plain candidate with last=2
        do_reset();
        set_req(0, 4'd1, 8'h00, 8'h00, 8'h01);
        set_req(1, 4'd2, 8'h01, 8'h00, 8'h02);
        req_valid = 3'b011;
        tick();
        req_valid = '0;
        tick();
`ifdef WB_ARB_BRANCH_PRIO_EN
        check("t5_first_gid", 32'(grant_id), 1);
        check("t5_first_flags", 32'(rob_flags), 1);
        tick();
        check("t5_second_gid", 32'(grant_id), 0);
`else
        check("t5_first_gid", 32'(grant_id), 0);
        check("t5_first_flags", 32'(rob_flags), 0);
        tick();
        check("t5_second_gid", 32'(grant_id), 1);
`endif
        check("t5_second_tx", 32'(rob_transmit), 1);

        // 6: reset while unit 2 holds a result
        set_req(2, 4'hE, 8'h30, 8'h44, 8'h77);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        check("t6_transmit", 32'(rob_transmit), 0);
        check("t6_robid", 32'(rob_robid), 0);
        check("t6_flags", 32'(rob_flags), 0);
        check("t6_wbs", 32'(rob_wbs), 0);
        check("t6_value", 32'(rob_value), 0);
        check("t6_grant_id", 32'(grant_id), 0);
        rst = 1'b0;
        tick();
        check("t6_discarded", 32'(rob_transmit), 0);
        set_req(0, 4'd4, 8'h00, 8'h00, 8'h04);
        set_req(1, 4'd5, 8'h00, 8'h00, 8'h05);
        set_req(2, 4'd6, 8'h00, 8'h00, 8'h06);
        req_valid = 3'b111;
        tick();
        req_valid = '0;
        tick();
        check("t6_post_gid", 32'(grant_id), 0);
        check("t6_post_robid", 32'(rob_robid), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
